// File: rtl/ysyx_220053_ifu.sv
// ysyx_220053_ifu: instruction fetch stage, one imem request in flight.
// Optional misaligned-redirect fault state: IFU_MISALIGN_CHECK_EN.
module ysyx_220053_ifu #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            misalign_fault
);

`ifdef IFU_MISALIGN_CHECK_EN
  typedef enum logic [2:0] {
    S_REQ, S_WAIT, S_HOLD, S_DROP, S_FAULT
  } state_t;
`else
  typedef enum logic [1:0] {
    S_REQ, S_WAIT, S_HOLD, S_DROP
  } state_t;
`endif

  state_t          r_state;
  state_t          w_state_nx;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nx;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            w_cap;
  logic            w_busy;
  logic [XLEN-1:0] w_rpc;

`ifdef IFU_MISALIGN_CHECK_EN
  logic            r_owe;
  logic            w_owe_nx;
  logic            w_mis;

  assign w_rpc = redirect_pc;
  assign w_mis = |redirect_pc[1:0];
  assign misalign_fault = (r_state == S_FAULT);
`else
  assign w_rpc = redirect_pc & ~XLEN'(3);
  assign misalign_fault = 1'b0;
`endif

  // a response is still owed by memory after this cycle
  always_comb begin
    w_busy = (r_state == S_REQ && imem_req_ready)
          || ((r_state == S_WAIT || r_state == S_DROP)
              && !imem_resp_valid);
`ifdef IFU_MISALIGN_CHECK_EN
    if (r_state == S_FAULT && r_owe && !imem_resp_valid)
      w_busy = 1'b1;
`endif
  end

  assign imem_req_valid = (r_state == S_REQ) && !rst;
  assign imem_addr      = r_pc;
  assign inst_valid     = (r_state == S_HOLD) && !redirect_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;

  // next state, next pc; redirect overrides normal flow
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_cap      = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    w_owe_nx   = r_owe;
`endif
    if (redirect_valid) begin
      w_pc_nx    = w_rpc;
      w_state_nx = w_busy ? S_DROP : S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
      if (w_mis) begin
        w_state_nx = S_FAULT;
        w_owe_nx   = w_busy;
      end else begin
        w_owe_nx   = 1'b0;
      end
`endif
    end else begin
      unique case (r_state)
        S_REQ: begin
          if (imem_req_ready)
            w_state_nx = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            w_cap      = 1'b1;
            w_state_nx = S_HOLD;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            w_pc_nx    = r_pc + XLEN'(4);
            w_state_nx = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid)
            w_state_nx = S_REQ;
        end
`ifdef IFU_MISALIGN_CHECK_EN
        S_FAULT: begin
          if (imem_resp_valid)
            w_owe_nx = 1'b0;
        end
`endif
        default: w_state_nx = S_REQ;
      endcase
    end
  end

  // state, pc and held instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_REQ;
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_inst_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      if (w_cap) begin
        r_inst    <= imem_resp_data;
        r_inst_pc <= r_pc;
      end
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  // response still owed while parked in FAULT
  always_ff @(posedge clk) begin
    if (rst)
      r_owe <= 1'b0;
    else
      r_owe <= w_owe_nx;
  end
`endif

endmodule
